hazard_pipe_tags: RTL and testbench

- Carries per-instruction control tags (opcode, register indices, valid) from fetch through decode, execute, memory and writeback.
- Applies the stall and flush requests produced by the forwarding/hazard logic.
- Its per-stage outputs are the op/register inputs that the forwarding unit consumes; the block sits directly upstream of it.
- Bubbles use an opcode that matches no forwarding or stall condition.

---
 rtl/hazard_pipe_tags.sv | 131 +++++++++++++
 tb/tb_hazard_pipe_tags.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_tags.sv
// Per-instruction control tags carried D->X->M->W with stall/flush handling.
// Stage outputs feed the forwarding unit directly from registers.
module hazard_pipe_tags #(
  parameter int              OP_W   = 5,
  parameter int              REG_W  = 5,
  parameter logic [OP_W-1:0] NOP_OP = '1,
  parameter int              CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [OP_W-1:0]  f_op,
  input  logic [REG_W-1:0] f_regX,
  input  logic [REG_W-1:0] f_regIn0,
  input  logic [REG_W-1:0] f_regIn1,
  input  logic [REG_W-1:0] f_regData,
  input  logic             FD_stall,
  input  logic             DX_stall,
  input  logic             XM_stall,
  input  logic             flush,
  output logic             f_hold,
  output logic [OP_W-1:0]  d_op,
  output logic [OP_W-1:0]  x_op,
  output logic [OP_W-1:0]  m_op,
  output logic [OP_W-1:0]  w_op,
  output logic [REG_W-1:0] d_regIn0,
  output logic [REG_W-1:0] d_regIn1,
  output logic [REG_W-1:0] x_regX,
  output logic [REG_W-1:0] x_regIn0,
  output logic [REG_W-1:0] x_regIn1,
  output logic [REG_W-1:0] m_regX,
  output logic [REG_W-1:0] m_regExe,
  output logic [REG_W-1:0] m_regData,
  output logic [REG_W-1:0] w_regOut,
  output logic             d_valid,
  output logic             x_valid,
  output logic             m_valid,
  output logic             w_valid,
  output logic             retire,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] regX;
    logic [REG_W-1:0] regIn0;
    logic [REG_W-1:0] regIn1;
    logic [REG_W-1:0] regData;
    logic             valid;
  } tag_t;

  localparam tag_t BUBBLE = '{
    op: NOP_OP, regX: '0, regIn0: '0,
    regIn1: '0, regData: '0, valid: 1'b0
  };
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  tag_t r_d, r_x, r_m, r_w;
  tag_t w_fetch;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic w_hx, w_hd, w_hf;

  // Holds cascade upstream: a held stage also holds everything behind it.
  assign w_hx = XM_stall;
  assign w_hd = DX_stall | w_hx;
  assign w_hf = FD_stall | w_hd;

  always_comb begin
    w_fetch = BUBBLE;
    if (f_valid) begin
      w_fetch.op      = f_op;
      w_fetch.regX    = f_regX;
      w_fetch.regIn0  = f_regIn0;
      w_fetch.regIn1  = f_regIn1;
      w_fetch.regData = f_regData;
      w_fetch.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d         <= BUBBLE;
      r_x         <= BUBBLE;
      r_m         <= BUBBLE;
      r_w         <= BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_w <= r_m;
      r_m <= w_hx ? BUBBLE : r_x;
      if (!w_hx)
        r_x <= w_hd ? BUBBLE : r_d;
      if (!w_hd)
        r_d <= (w_hf || flush) ? BUBBLE : w_fetch;
      if (w_hf && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && !w_hd && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign f_hold       = w_hf;
  assign d_op         = r_d.op;
  assign d_regIn0     = r_d.regIn0;
  assign d_regIn1     = r_d.regIn1;
  assign d_valid      = r_d.valid;
  assign x_op         = r_x.op;
  assign x_regX       = r_x.regX;
  assign x_regIn0     = r_x.regIn0;
  assign x_regIn1     = r_x.regIn1;
  assign x_valid      = r_x.valid;
  assign m_op         = r_m.op;
  assign m_regX       = r_m.regX;
  assign m_regExe     = r_m.regIn0;
  assign m_regData    = r_m.regData;
  assign m_valid      = r_m.valid;
  assign w_op         = r_w.op;
  assign w_regOut     = r_w.regX;
  assign w_valid      = r_w.valid;
  assign retire       = r_w.valid;
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

  logic w_unused;
  assign w_unused = ^{r_d.regX, r_d.regData, r_x.regData,
                      r_m.regIn1, r_w.regIn0, r_w.regIn1,
                      r_w.regData};

endmodule

// File: tb/tb_hazard_pipe_tags.sv
// Directed bench for hazard_pipe_tags with a retirement scoreboard.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_hazard_pipe_tags;

  localparam int OP_W  = 5;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam logic [4:0] NOP = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  logic f_valid;
  logic [4:0] f_op, f_regX, f_regIn0, f_regIn1, f_regData;
  logic FD_stall, DX_stall, XM_stall, flush;
  logic f_hold;
  logic [4:0] d_op, x_op, m_op, w_op;
  logic [4:0] d_regIn0, d_regIn1;
  logic [4:0] x_regX, x_regIn0, x_regIn1;
  logic [4:0] m_regX, m_regExe, m_regData, w_regOut;
  logic d_valid, x_valid, m_valid, w_valid, retire;
  logic [3:0] stall_cycles, flush_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  hazard_pipe_tags #(
    .OP_W(OP_W), .REG_W(REG_W),
    .NOP_OP(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_op(f_op),
    .f_regX(f_regX), .f_regIn0(f_regIn0),
    .f_regIn1(f_regIn1), .f_regData(f_regData),
    .FD_stall(FD_stall), .DX_stall(DX_stall),
    .XM_stall(XM_stall), .flush(flush),
    .f_hold(f_hold),
    .d_op(d_op), .x_op(x_op), .m_op(m_op), .w_op(w_op),
    .d_regIn0(d_regIn0), .d_regIn1(d_regIn1),
    .x_regX(x_regX), .x_regIn0(x_regIn0),
    .x_regIn1(x_regIn1),
    .m_regX(m_regX), .m_regExe(m_regExe),
    .m_regData(m_regData), .w_regOut(w_regOut),
    .d_valid(d_valid), .x_valid(x_valid),
    .m_valid(m_valid), .w_valid(w_valid),
    .retire(retire),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, retire against the scoreboard.
  task automatic cyc();
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (retire === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", {w_op, w_regOut}, 10'h3ff);
      end else begin
        e = sb.pop_front();
        chk("retire_tags", {w_op, w_regOut}, e);
      end
    end
  endtask

  task automatic fetch(input logic [4:0] op, input logic [4:0] rx,
                       input logic [4:0] r0, input logic [4:0] rd,
                       input bit exp_retire);
    f_valid = 1'b1; f_op = op; f_regX = rx;
    f_regIn0 = r0; f_regIn1 = 5'd1; f_regData = rd;
    if (exp_retire) sb.push_back({op, rx});
  endtask

  task automatic idle();
    f_valid = 1'b0; f_op = 5'd0; f_regX = 5'd0;
    f_regIn0 = 5'd0; f_regIn1 = 5'd0; f_regData = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    FD_stall = 0; DX_stall = 0; XM_stall = 0; flush = 0;
    // Reset state
    cyc(); cyc();
    chk("rst_ops", {d_op, x_op, m_op, w_op}, {4{NOP}});
    chk("rst_valid", {d_valid, x_valid, m_valid, w_valid, retire}, 0);
    chk("rst_regs", {d_regIn0, x_regX, m_regX, m_regData, w_regOut}, 0);
    chk("rst_cnt", {stall_cycles, flush_count}, 0);
    FD_stall = 1; #1;
    chk("rst_fhold", f_hold, 1);
    FD_stall = 0; #1;
    chk("rst_fhold_lo", f_hold, 0);

    // Flow
    rst = 0;
    fetch(5'b00011, 5'd3, 5'd0, 5'd0, 1); cyc();
    chk("flow_d", {d_op, d_valid}, {5'b00011, 1'b1});
    fetch(5'b00100, 5'd4, 5'd0, 5'd0, 1); cyc();
    chk("flow_x", {x_op, d_op}, {5'b00011, 5'b00100});
    idle(); cyc();
    chk("flow_m", {m_op, x_op, d_op}, {5'b00011, 5'b00100, NOP});
    cyc();
    chk("flow_w", {w_op, w_regOut, retire}, {5'b00011, 5'd3, 1'b1});
    cyc();
    chk("flow_w2", {w_op, w_regOut}, {5'b00100, 5'd4});
    cyc(); cyc();

    // Load-use
    fetch(5'b01101, 5'd6, 5'd2, 5'd5, 1); cyc();
    fetch(5'b00001, 5'd7, 5'd6, 5'd0, 1); cyc();
    fetch(5'b00010, 5'd8, 5'd0, 5'd0, 1); cyc();
    chk("lu_m_tags", {m_op, m_regData, m_regExe},
        {5'b01101, 5'd5, 5'd2});
    fetch(5'b00101, 5'd9, 5'd0, 5'd0, 0);
    XM_stall = 1; #1;
    chk("lu_fhold", f_hold, 1);
    cyc();
    chk("lu_bubble", {m_op, m_valid}, {NOP, 1'b0});
    chk("lu_w", w_op, 5'b01101);
    chk("lu_hold", {x_op, d_op}, {5'b00001, 5'b00010});
    chk("lu_stall", stall_cycles, 1);
    XM_stall = 0;
    fetch(5'b00101, 5'd9, 5'd0, 5'd0, 1); cyc();
    chk("lu_late", {m_op, x_op, d_op},
        {5'b00001, 5'b00010, 5'b00101});
    idle();
    repeat (5) cyc();

    // DX_stall for 2 cycles
    do_reset();
    fetch(5'b00110, 5'd10, 5'd0, 5'd0, 1); cyc();
    fetch(5'b00111, 5'd11, 5'd0, 5'd0, 1); cyc();
    fetch(5'b01000, 5'd12, 5'd0, 5'd0, 0);
    DX_stall = 1; #1;
    chk("dx_fhold", f_hold, 1);
    cyc();
    chk("dx_c1", {d_op, x_op, x_valid, m_op},
        {5'b00111, NOP, 1'b0, 5'b00110});
    cyc();
    chk("dx_c2", {d_op, x_op, m_op}, {5'b00111, NOP, NOP});
    chk("dx_stall", stall_cycles, 2);
    DX_stall = 0;
    fetch(5'b01000, 5'd12, 5'd0, 5'd0, 1); cyc();
    chk("dx_resume", {d_op, x_op}, {5'b01000, 5'b00111});
    idle();
    repeat (5) cyc();

    // Flush without stall
    do_reset();
    fetch(5'b01001, 5'd13, 5'd0, 5'd0, 0);
    flush = 1; cyc();
    chk("fl_d", {d_op, d_valid}, {NOP, 1'b0});
    chk("fl_cnt", flush_count, 1);
    flush = 0;
    fetch(5'b01010, 5'd14, 5'd0, 5'd0, 1); cyc();
    chk("fl_next", {d_op, d_valid}, {5'b01010, 1'b1});
    idle();
    repeat (5) cyc();

    // Flush coincident with stalls
    do_reset();
    fetch(5'b01011, 5'd15, 5'd0, 5'd0, 1); cyc();
    fetch(5'b01100, 5'd16, 5'd0, 5'd0, 0);
    flush = 1; DX_stall = 1; cyc();
    chk("fl_dx_d", {d_op, d_valid}, {5'b01011, 1'b1});
    chk("fl_dx_cnt", flush_count, 0);
    DX_stall = 0; FD_stall = 1; cyc();
    chk("fl_fd_d", {d_op, d_valid, x_op}, {NOP, 1'b0, 5'b01011});
    chk("fl_fd_cnt", {flush_count, stall_cycles}, {4'd1, 4'd2});
    flush = 0; FD_stall = 0; idle();
    repeat (5) cyc();

    // Reset mid-stream discards in-flight work
    fetch(5'b00011, 5'd1, 5'd0, 5'd0, 0); cyc();
    fetch(5'b00100, 5'd2, 5'd0, 5'd0, 0); cyc();
    idle(); do_reset();
    chk("mid_rst", {d_valid, x_valid, m_valid}, 0);
    repeat (4) cyc();

    // Counter saturation
    FD_stall = 1;
    repeat (15) cyc();
    chk("sat_15", stall_cycles, 15);
    repeat (5) cyc();
    chk("sat_hold", stall_cycles, 15);
    FD_stall = 0;
    do_reset();
    chk("sat_rst", stall_cycles, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
